seq_multu: RTL and testbench



---
 rtl/seq_multu_if.sv | 12 +
 rtl/seq_multu.sv | 70 +++++++
 tb/tb_seq_multu.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_multu_if.sv
// Request/operand/result bundle for the sequential unsigned multiplier.
interface seq_multu_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 Multu;
  logic [WIDTH-1:0]     dataA;
  logic [WIDTH-1:0]     dataB;
  logic [2*WIDTH-1:0]   dataOut;

  modport master (output Multu, dataA, dataB, input dataOut);
  modport slave  (input Multu, dataA, dataB, output dataOut);
endinterface

// File: rtl/seq_multu.sv
// Shift-add unsigned WIDTH x WIDTH multiplier: one load edge plus WIDTH iteration
// edges; the product register only updates on the final iteration.
module seq_multu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  seq_multu_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   dataout_q;
  logic [2*WIDTH-1:0]   sum_d;

  always_comb begin
    sum_d = prod_q;
    if (mplier_q[0]) sum_d = prod_q + mcand_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      dataout_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Multu) begin
            mcand_q  <= {{WIDTH{1'b0}}, bus.dataA};
            mplier_q <= bus.dataB;
            prod_q   <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (!bus.Multu) begin
            // Abort: partial product is simply abandoned.
            state_q <= IDLE;
          end else begin
            prod_q   <= sum_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              dataout_q <= sum_d;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dataOut = dataout_q;

endmodule

// File: tb/tb_seq_multu.sv
// Scoreboard bench for seq_multu: expected products queued at load, popped at completion.
module tb_seq_multu;

  logic clk;
  logic reset;

  seq_multu_if #(.WIDTH(32)) bus ();

  seq_multu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, required 0x%016h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; the next edge is the load edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus.dataA = a;
    bus.dataB = b;
    bus.Multu = 1'b1;
    exp_q.push_back({32'b0, a} * {32'b0, b});
  endtask

  // Waits out the rest of the 33-edge operation, `done` edges already elapsed.
  task automatic finish_op(input int unsigned done, input string tag);
    logic [63:0] e;
    repeat (32 - done) @(posedge clk);
    #1 check({tag, "_hold"}, bus.dataOut, last_res);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, bus.dataOut, e);
    last_res = e;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input string tag);
    start(a, b);
    finish_op(0, tag);
    bus.Multu = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    bus.Multu = 1'b0;
    bus.dataA = '0;
    bus.dataB = '0;
    last_res  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset", bus.dataOut, 64'd0);
    repeat (5) @(posedge clk);
    #1 check("idle", bus.dataOut, 64'd0);

    // First op, then back-to-back with operands changed at completion time.
    start(32'd15, 32'd10);
    finish_op(0, "15x10");
    start(32'd20, 32'd30);
    finish_op(0, "20x30");
    bus.Multu = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1 check("drop_hold", bus.dataOut, last_res);

    op(32'hFFFF_FFFF, 32'd2, "unsigned_x2");
    op(32'd1000, 32'd1000, "1000x1000");
    op(32'd0, 32'd12345, "zero_a");
    op(32'd12345, 32'd0, "zero_b");
    op(32'h8000_0000, 32'h8000_0000, "msb");

    // Abort after 10 cycles: no result, prior value retained.
    bus.dataA = 32'd7;
    bus.dataB = 32'd9;
    bus.Multu = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.Multu = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("abort", bus.dataOut, last_res);
    op(32'd7, 32'd9, "7x9");

    // Operand change mid-RUN must not affect the latched operands.
    start(32'd123456, 32'd789);
    repeat (5) @(posedge clk);
    #1;
    bus.dataA = 32'd999;
    bus.dataB = 32'd5;
    finish_op(5, "stable");
    bus.Multu = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset between edges mid-RUN.
    start(32'd5, 32'd6);
    void'(exp_q.pop_front());
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1 check("async_rst", bus.dataOut, 64'd0);
    bus.Multu = 1'b0;
    #1 reset = 1'b0;
    last_res = '0;
    repeat (40) @(posedge clk);
    #1 check("post_rst_idle", bus.dataOut, 64'd0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_x_max");

    for (int i = 0; i < 4; i++) begin
      op($urandom, $urandom, "random");
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
